add_arb_ctrl: RTL and testbench

ADD_ARB_CTRL -- requirements
Module: add_arb_ctrl

---
 rtl/add_arb_ctrl.sv | 174 +++++++++++++++++
 tb/tb_add_arb_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_arb_ctrl.sv
// Round-robin arbiter that time-shares one 8-bit adder slice among N_REQ requesters.
// Each accepted operation takes a low-byte pass, a high-byte pass, then a response handshake.
module add_arb_ctrl #(
    parameter int N_REQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [15*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    input  logic [N_REQ-1:0]     req_wide,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [16:0]          resp_data,
    output logic [1:0]           resp_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t       state_r;
    logic [1:0]   ptr_r;
    logic [1:0]   id_r;
    logic [15:0]  a_r;
    logic [15:0]  b_r;
    logic [7:0]   s_lo_r;
    logic         c_r;
    logic         wide_r;
    logic         resp_valid_r;
    logic [16:0]  resp_data_r;
    logic [1:0]   resp_id_r;

    logic [2:0]        pick_s;
    logic              grant_s;
    logic [1:0]        grant_id_s;
    logic [1:0]        ptr_nxt_s;
    logic [N_REQ-1:0]  req_ready_s;
    logic [14:0]       a_sel_s;
    logic [15:0]       b_sel_s;
    logic              wide_sel_s;
    logic [7:0]        add_x_s;
    logic [7:0]        add_y_s;
    logic              add_ci_s;
    logic [8:0]        add_sum_s;

    // First set request at or after p, wrapping; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] v, input logic [1:0] p);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < N_REQ; i++) begin
            if (!r[2] && v[i] && (2'(i) >= p)) begin
                r = {1'b1, 2'(i)};
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!r[2] && v[i] && (2'(i) < p)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    // Grant selection and per-requester accept strobes, only in IDLE and out of reset.
    always_comb begin
        pick_s      = rr_pick(req_valid, ptr_r);
        grant_s     = pick_s[2] && (state_r == IDLE) && rst_n;
        grant_id_s  = pick_s[1:0];
        req_ready_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_s[i] = grant_s && (grant_id_s == 2'(i));
        end
        if (grant_id_s == 2'(N_REQ - 1)) begin
            ptr_nxt_s = 2'd0;
        end else begin
            ptr_nxt_s = grant_id_s + 2'd1;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        a_sel_s    = 15'd0;
        b_sel_s    = 16'd0;
        wide_sel_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            a_sel_s    = (grant_id_s == 2'(i)) ? req_a[15*i +: 15] : a_sel_s;
            b_sel_s    = (grant_id_s == 2'(i)) ? req_b[16*i +: 16] : b_sel_s;
            wide_sel_s = (grant_id_s == 2'(i)) ? req_wide[i]       : wide_sel_s;
        end
    end

    // The single shared 8-bit slice: low bytes in LO, high bytes plus carry in HI.
    always_comb begin
        add_x_s   = 8'd0;
        add_y_s   = 8'd0;
        add_ci_s  = 1'b0;
        if (state_r == HI) begin
            add_x_s  = a_r[15:8];
            add_y_s  = b_r[15:8];
            add_ci_s = c_r;
        end else begin
            add_x_s  = a_r[7:0];
            add_y_s  = b_r[7:0];
            add_ci_s = 1'b0;
        end
        add_sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {8'd0, add_ci_s};
    end

    // Operation sequencer with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ptr_r        <= 2'd0;
            id_r         <= 2'd0;
            a_r          <= 16'd0;
            b_r          <= 16'd0;
            s_lo_r       <= 8'd0;
            c_r          <= 1'b0;
            wide_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 17'd0;
            resp_id_r    <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        a_r     <= {1'b0, a_sel_s};
                        b_r     <= b_sel_s;
                        wide_r  <= wide_sel_s;
                        id_r    <= grant_id_s;
                        ptr_r   <= ptr_nxt_s;
                        state_r <= LO;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LO: begin
                    s_lo_r  <= add_sum_s[7:0];
                    c_r     <= add_sum_s[8];
                    state_r <= HI;
                end
                HI: begin
                    // Carry out only survives in the 17-bit context.
                    resp_data_r  <= {wide_r & add_sum_s[8], add_sum_s[7:0], s_lo_r};
                    resp_id_r    <= id_r;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r      <= RESP;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_id    = resp_id_r;

endmodule

// File: tb/tb_add_arb_ctrl.sv
// Self-checking bench for add_arb_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model (grant, fixed 3-cycle latency, hold until handshake).
module tb_add_arb_ctrl;

    localparam int N = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [15*N-1:0]  req_a;
    logic [16*N-1:0]  req_b;
    logic [N-1:0]     req_wide;
    logic             resp_valid;
    logic             resp_ready;
    logic [16:0]      resp_data;
    logic [1:0]       resp_id;

    add_arb_ctrl #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_wide   (req_wide),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int cyc;

    // transaction-level model
    bit          m_busy;
    int          m_age;
    int          m_ptr;
    logic [16:0] m_data;
    logic [1:0]  m_id;

    // observations of the DUT
    int          grant_q[$];
    int          grant_cyc_q[$];
    int          resp_q[$];
    int          last_grant_cyc;
    int          first_rv_cyc;
    int          rv_count;
    int          n_resp;
    bit          prev_rv;
    logic [16:0] last_data;
    logic [1:0]  last_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int m_pick(input logic [N-1:0] v, input int p);
        int r;
        int idx;
        r = -1;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            for (int i = 0; i < N; i++) begin
                if (r < 0 && i == idx && v[i]) r = i;
            end
        end
        return r;
    endfunction

    task automatic rand_ops();
        logic [31:0] r;
        r = $urandom; req_a = r[15*N-1:0];
        r = $urandom; req_b = r[16*N-1:0];
        r = $urandom; req_wide = r[N-1:0];
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy;
        bit           exp_rv;
        int           g;
        logic [14:0]  a;
        logic [15:0]  b;
        logic         w;
        logic [16:0]  sum;
        #1;
        g = m_pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (rst_n && !m_busy) begin
            for (int i = 0; i < N; i++) if (i == g) exp_rdy[i] = 1'b1;
        end
        exp_rv = rst_n && m_busy && (m_age == 3);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("resp_data", 32'(resp_data), 32'(m_data));
            chk("resp_id", 32'(resp_id), 32'(m_id));
        end
        if (!rst_n) begin
            chk("rst_resp_data", 32'(resp_data), 32'd0);
            chk("rst_resp_id", 32'(resp_id), 32'd0);
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                grant_q.push_back(i);
                grant_cyc_q.push_back(cyc);
                last_grant_cyc = cyc;
            end
        end
        if (resp_valid && !prev_rv) first_rv_cyc = cyc;
        if (resp_valid) rv_count++;
        if (resp_valid && resp_ready) begin
            last_data = resp_data;
            last_id   = resp_id;
            resp_q.push_back(int'(resp_id));
        end
        prev_rv = resp_valid;
        // advance model to the next cycle
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            if (g >= 0) begin
                a = 15'd0; b = 16'd0; w = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (i == g) begin
                        a = req_a[15*i +: 15];
                        b = req_b[16*i +: 16];
                        w = req_wide[i];
                    end
                end
                sum    = 17'(a) + 17'(b);
                m_data = w ? sum : {1'b0, sum[15:0]};
                m_id   = 2'(g);
                m_busy = 1'b1;
                m_age  = 1;
                m_ptr  = (g + 1) % N;
            end
        end else if (m_age < 3) begin
            m_age++;
        end else if (resp_ready) begin
            m_busy = 1'b0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive0(input logic [14:0] a, input logic [15:0] b, input logic w);
        rand_ops();
        req_valid  = 2'b01;
        req_a[14:0] = a;
        req_b[15:0] = b;
        req_wide[0] = w;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        m_busy = 1'b0; m_age = 0; m_ptr = 0; m_data = 17'd0; m_id = 2'd0;
        last_grant_cyc = 0; first_rv_cyc = 0; rv_count = 0; prev_rv = 1'b0;
        last_data = 17'd0; last_id = 2'd0; n_resp = 0;
        rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_wide = '0; resp_ready = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);

        // reset held with requests pending: no strobes, outputs zero
        req_valid = 2'b11; rand_ops();
        repeat (2) step();
        req_valid = '0; rst_n = 1'b1;
        step();

        // widest operands, 17-bit context
        drive0(15'h7FFF, 16'hFFFF, 1'b1); resp_ready = 1'b1;
        step();
        req_valid = '0;
        repeat (4) step();
        chk("first_grant_ptr0", 32'(grant_q[$]), 32'd0);
        chk("wide_data_lit", 32'(last_data), 32'h17FFE);
        chk("wide_id_lit", 32'(last_id), 32'd0);
        chk("latency_wide", 32'(first_rv_cyc - last_grant_cyc), 32'd3);
        chk("model_pin_wide", 32'(m_data), 32'h17FFE);

        // same operands, 16-bit context drops the carry
        drive0(15'h7FFF, 16'hFFFF, 1'b0);
        step();
        req_valid = '0;
        repeat (4) step();
        chk("narrow_data_lit", 32'(last_data), 32'h07FFE);
        chk("latency_narrow", 32'(first_rv_cyc - last_grant_cyc), 32'd3);
        chk("model_pin_narrow", 32'(m_data), 32'h07FFE);

        // two requesters together after reset: 0 then 1, four cycles apart
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        grant_q.delete(); grant_cyc_q.delete(); resp_q.delete();
        req_valid = 2'b11;
        repeat (8) begin rand_ops(); step(); end
        req_valid = '0;
        repeat (2) step();
        chk("rr_grant_count", 32'(grant_q.size()), 32'd2);
        chk("rr_resp_count", 32'(resp_q.size()), 32'd2);
        if (grant_q.size() == 2 && resp_q.size() == 2) begin
            chk("rr_grant0", 32'(grant_q[0]), 32'd0);
            chk("rr_grant1", 32'(grant_q[1]), 32'd1);
            chk("rr_resp_id0", 32'(resp_q[0]), 32'd0);
            chk("rr_resp_id1", 32'(resp_q[1]), 32'd1);
            chk("rr_interval", 32'(grant_cyc_q[1] - grant_cyc_q[0]), 32'd4);
        end

        // back-pressure: response held for 5 cycles, requests ignored meanwhile
        resp_ready = 1'b0;
        drive0(15'h1234, 16'hABCD, 1'b1);
        step();
        req_valid = '0;
        repeat (2) step();
        rv_count = 0;
        repeat (5) begin
            req_valid = 2'($urandom_range(0, 3)); rand_ops();
            step();
        end
        req_valid = '0; resp_ready = 1'b1;
        step();
        step();
        chk("hold_rv_cycles", 32'(rv_count), 32'd6);
        chk("hold_data_lit", 32'(last_data), 32'h0BE01);

        // reset during HI of a grant to req1 abandons it
        req_valid = 2'b10; rand_ops();
        step();
        req_valid = '0;
        step();
        n_resp = resp_q.size();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("abandon_no_resp", 32'(resp_q.size()), 32'(n_resp));
        req_valid = 2'b11; rand_ops();
        step();
        chk("post_rst_grant0", 32'(grant_q[$]), 32'd0);
        req_valid = '0;
        repeat (4) step();

        // lone requester 1 held valid: grants every 4 cycles
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        grant_q.delete(); grant_cyc_q.delete();
        req_valid = 2'b10;
        repeat (12) begin rand_ops(); step(); end
        req_valid = '0;
        repeat (4) step();
        chk("solo_grant_count", 32'(grant_q.size()), 32'd3);
        if (grant_q.size() == 3) begin
            chk("solo_id0", 32'(grant_q[0]), 32'd1);
            chk("solo_id2", 32'(grant_q[2]), 32'd1);
            chk("solo_gap01", 32'(grant_cyc_q[1] - grant_cyc_q[0]), 32'd4);
            chk("solo_gap12", 32'(grant_cyc_q[2] - grant_cyc_q[1]), 32'd4);
        end
        chk("model_pin_ptr", 32'(m_ptr), 32'd0);

        // randomized traffic with occasional asynchronous resets
        repeat (800) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            req_valid  = 2'($urandom_range(0, 3));
            resp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            step();
        end
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
